// File: rtl/hough_peak_reader.sv
// hough_peak_reader: scans a Hough accumulator row by row and pushes {rho,theta} of cells >= THRESHOLD into a FIFO.
// Define HOUGH_PEAK_CLEAR_EN to zero every scanned cell so the accumulator is clean for the next frame.
module hough_peak_reader #(
  parameter int THETAS = 180,
  parameter int RHOS = 512,
  parameter int ADDR_BITS = 17,
  parameter int COUNT_BITS = 8,
  parameter int RHO_BITS = 10,
  parameter int THETA_BITS = 8,
  parameter int THRESHOLD = 20,
  parameter int MAX_PEAKS = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  output logic                           accum_rd_en,
  output logic [ADDR_BITS-1:0]           accum_rd_addr,
  input  logic [COUNT_BITS-1:0]          accum_rd_data,
  output logic                           accum_wr_en,
  output logic [ADDR_BITS-1:0]           accum_wr_addr,
  output logic                           out_wr_en,
  input  logic                           out_full,
  output logic [RHO_BITS+THETA_BITS-1:0] out_dout,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    peak_count
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, EMIT, DONE} state_t;
  state_t state;
  logic [RHO_BITS-1:0] rho;
  logic [THETA_BITS-1:0] theta;
  logic row_end, last, hit, step, finish;
  assign row_end = theta == THETA_BITS'(THETAS - 1);
  assign last = row_end && rho == RHO_BITS'(RHOS - 1);
  assign hit = accum_rd_data >= COUNT_BITS'(THRESHOLD);
  // The write must follow out_full in the same cycle, so it is decoded from state.
  assign out_wr_en = state == EMIT && !out_full;
  assign step = (state == CAPTURE && !hit) || out_wr_en;
  assign finish = last || (out_wr_en && peak_count == 16'(MAX_PEAKS - 1));
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rho <= '0;
      theta <= '0;
      peak_count <= '0;
      accum_rd_en <= 1'b0;
      accum_rd_addr <= '0;
      out_dout <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      accum_rd_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          busy <= 1'b1;
          rho <= '0;
          theta <= '0;
          peak_count <= '0;
          accum_rd_en <= 1'b1;
          accum_rd_addr <= '0;
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: if (hit) begin
          state <= EMIT;
          out_dout <= {rho, theta};
        end
        EMIT: if (out_wr_en) peak_count <= peak_count + 16'd1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
      // Row-major scan keeps the address a plain linear counter.
      if (step && finish) begin
        state <= DONE;
        done <= 1'b1;
      end else if (step) begin
        state <= ISSUE;
        accum_rd_en <= 1'b1;
        accum_rd_addr <= accum_rd_addr + 1'b1;
        theta <= row_end ? '0 : theta + 1'b1;
        rho <= row_end ? rho + 1'b1 : rho;
      end
    end
  end
`ifdef HOUGH_PEAK_CLEAR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      accum_wr_en <= 1'b0;
      accum_wr_addr <= '0;
    end else begin
      accum_wr_en <= state == ISSUE;
      if (state == ISSUE) accum_wr_addr <= accum_rd_addr;
    end
  end
`else
  assign accum_wr_en = 1'b0;
  assign accum_wr_addr = '0;
`endif
endmodule

// File: doc/hough_peak_reader.md
HOUGH_PEAK_READER -- requirements
Module: hough_peak_reader

Interface
REQ-001 SHALL have parameter THETAS, default 180, number of theta bins per rho row.
REQ-002 SHALL have parameter RHOS, default 512, number of rho rows.
REQ-003 SHALL have parameter ADDR_BITS, default 17, accumulator address width.
REQ-004 SHALL have parameter COUNT_BITS, default 8, accumulator cell width.
REQ-005 SHALL have parameters RHO_BITS, default 10, and THETA_BITS, default 8, for the output field widths.
REQ-006 SHALL have parameter THRESHOLD, default 20, minimum vote count for a peak.
REQ-007 SHALL have parameter MAX_PEAKS, default 16, the peak limit per scan.
REQ-008 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-010 SHALL have port start, input, 1, one-cycle pulse meaning the accumulator is complete.
REQ-011 SHALL have ports accum_rd_en, output, 1, and accum_rd_addr, output, ADDR_BITS: the read request.
REQ-012 SHALL have port accum_rd_data, input, COUNT_BITS, valid exactly one cycle after accum_rd_en.
REQ-013 SHALL have ports accum_wr_en, output, 1, and accum_wr_addr, output, ADDR_BITS: the clear-write path.
REQ-014 SHALL have ports out_wr_en, output, 1, out_full, input, 1, and out_dout, output, RHO_BITS+THETA_BITS: the peak FIFO write side.
REQ-015 SHALL have ports busy, output, 1; done, output, 1; peak_count, output, 16.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, CAPTURE, EMIT and DONE.
REQ-017 SHALL scan cells with rho as the outer loop and theta as the inner loop, starting at (0,0); address = rho*THETAS + theta.
REQ-018 SHALL, in IDLE, go to ISSUE on start and clear rho, theta and peak_count.
REQ-019 SHALL, in ISSUE, assert accum_rd_en for one cycle with the current address, then go to CAPTURE.
REQ-020 SHALL, in CAPTURE, register accum_rd_data, then go to EMIT if the value is >= THRESHOLD, otherwise advance.
REQ-021 SHALL, in EMIT, stall with out_wr_en=0 while out_full=1; otherwise assert out_wr_en for one cycle with out_dout={rho,theta}, increment peak_count, and advance.
REQ-022 SHALL advance as follows: theta==THETAS-1 wraps theta to 0 and increments rho; after the last cell (RHOS-1, THETAS-1) the FSM goes to DONE; otherwise it goes to ISSUE.
REQ-023 SHALL go to DONE immediately after the write that makes peak_count==MAX_PEAKS, skipping the remaining cells.
REQ-024 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE; peak_count SHALL hold until the next start.
REQ-025 SHALL assert busy in every state except IDLE, and SHALL ignore start while busy.
REQ-026 SHALL keep out_dout stable while stalled in EMIT.
REQ-027 SHALL give a non-peak cell a 2-cycle cost and an unstalled peak a 3-cycle cost.

Reset
REQ-028 SHALL, on reset, enter IDLE, clear rho, theta and peak_count, and drive accum_rd_en, accum_wr_en, out_wr_en, busy and done to 0, with addresses and out_dout at 0.
REQ-029 SHALL, on reset asserted mid-scan, abandon the scan with no further reads or writes, including a stalled EMIT.

Configuration
REQ-030 SHALL, when macro HOUGH_PEAK_CLEAR_EN is defined, assert accum_wr_en for one cycle in CAPTURE with accum_wr_addr equal to the captured address, writing zero so that each scan clears the accumulator.
REQ-031 SHALL, when HOUGH_PEAK_CLEAR_EN is undefined, tie accum_wr_en and accum_wr_addr to 0.

Verification
REQ-032 SHALL cover this scenario: THETAS=4, RHOS=3, THRESHOLD=5, all cells 0, start pulse -> 12 reads at addresses 0..11, no out_wr_en, done 24 cycles after ISSUE entry, peak_count=0.
REQ-033 SHALL cover this scenario: same parameters, cell 6=5 and cell 9=4 -> exactly one write, out_dout={rho=1,theta=2}, peak_count=1.
REQ-034 SHALL cover this scenario: cell 6=9 with out_full held high for 5 cycles -> out_wr_en held 0 and out_dout stable for 5 cycles, then one write.
REQ-035 SHALL cover this scenario: MAX_PEAKS=2 with all cells=7 -> writes {0,0} and {0,1}, then done, with no read at address 2.
REQ-036 SHALL cover this scenario: reset asserted during cycle 5 of a scan, then a new start -> the scan restarts at address 0 with peak_count=0.
REQ-037 SHALL cover this scenario: with HOUGH_PEAK_CLEAR_EN defined, after a scan -> every address 0..11 written once with 0; a second scan yields peak_count=0.
